// File: rtl/riscv_crypto_sm4_iter.sv
// Iterative SM4 block cipher engine: 32-round key expansion into a round-key store, then
// encrypt/decrypt with valid/ready handshakes. Define RISCV_CRYPTO_SM4_ITER_DEC_EN for decryption.

module riscv_crypto_sm4_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};

  // Entry 0 sits in the top byte of the table, so index from the top.
  assign out_byte = SBOX[{~in_byte, 3'b000} +: 8];
endmodule

module riscv_crypto_sm4_iter #(
  parameter int UNROLL = 1
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         key_loaded,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_dec,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_err
);
  localparam logic [4:0]   STEP = 5'(UNROLL);
  localparam logic [4:0]   LAST = 5'(32 - UNROLL);
  localparam logic [127:0] FK   = 128'ha3b1bac656aa3350677d9197b27022dc;

  typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_READY, S_CRYPT, S_DONE} state_e;

  function automatic logic [31:0] ck_of(input logic [4:0] i);
    logic [7:0] idx;
    ck_of = 32'h0;
    for (int j = 0; j < 4; j++) begin
      idx = {1'b0, i, 2'b00} + 8'(j);
      ck_of[31-8*j -: 8] = idx * 8'd7;
    end
  endfunction

  function automatic logic [31:0] l_key(input logic [31:0] b);
    l_key = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  function automatic logic [31:0] l_data(input logic [31:0] b);
    l_data = b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction

  state_e       state_q, state_d;
  logic [4:0]   ctr_q, ctr_d;
  logic [127:0] kx_q, kx_d, x_q, x_d, out_data_q, out_data_d;
  logic         dec_q, dec_d, out_err_q, out_err_d, key_loaded_q, key_loaded_d;
  logic [31:0]  rk_q [32];
  logic [127:0] kc_s [UNROLL+1];
  logic [127:0] xc_s [UNROLL+1];
  logic         key_hs_s, in_hs_s, last_s;

  assign key_hs_s = key_valid & key_ready;
  assign in_hs_s  = in_valid & in_ready;
  assign last_s   = (ctr_q == LAST);
  assign kc_s[0]  = kx_q;
  assign xc_s[0]  = x_q;

  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    logic [4:0]  ri_s;
    logic [31:0] kt_s, kb_s, xt_s, xb_s, rk_s;
    assign ri_s = ctr_q + 5'(u);
    assign kt_s = kc_s[u][95:64] ^ kc_s[u][63:32] ^ kc_s[u][31:0] ^ ck_of(ri_s);
`ifdef RISCV_CRYPTO_SM4_ITER_DEC_EN
    assign rk_s = dec_q ? rk_q[~ri_s] : rk_q[ri_s];
`else
    assign rk_s = rk_q[ri_s];
`endif
    assign xt_s = xc_s[u][95:64] ^ xc_s[u][63:32] ^ xc_s[u][31:0] ^ rk_s;
    for (genvar b = 0; b < 4; b++) begin : g_sbox
      riscv_crypto_sm4_sbox u_ks (.in_byte(kt_s[8*b +: 8]), .out_byte(kb_s[8*b +: 8]));
      riscv_crypto_sm4_sbox u_ds (.in_byte(xt_s[8*b +: 8]), .out_byte(xb_s[8*b +: 8]));
    end
    assign kc_s[u+1] = {kc_s[u][95:0], kc_s[u][127:96] ^ l_key(kb_s)};
    assign xc_s[u+1] = {xc_s[u][95:0], xc_s[u][127:96] ^ l_data(xb_s)};
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (key_hs_s) state_d = S_KEYEXP;
      S_KEYEXP: if (last_s) state_d = S_READY;
      S_READY: begin
        if (key_hs_s) state_d = S_KEYEXP;
        else if (in_hs_s) state_d = S_CRYPT;
      end
`ifdef RISCV_CRYPTO_SM4_ITER_DEC_EN
      S_CRYPT:  if (last_s) state_d = S_DONE;
`else
      S_CRYPT:  if (dec_q || last_s) state_d = S_DONE;
`endif
      S_DONE:   if (out_ready) state_d = S_READY;
      default:  state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; a pending key blocks block acceptance.
  always_comb begin
    key_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  key_ready = 1'b1;
      S_READY: begin
        key_ready = 1'b1;
        in_ready  = ~key_valid;
      end
      S_DONE:  out_valid = 1'b1;
      default: key_ready = 1'b0;
    endcase
  end

  // Datapath next values.
  always_comb begin
    ctr_d        = ctr_q;
    kx_d         = kx_q;
    x_d          = x_q;
    dec_d        = dec_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    key_loaded_d = key_loaded_q;
    if (key_hs_s) begin
      kx_d         = key ^ FK;
      ctr_d        = 5'd0;
      key_loaded_d = 1'b0;
    end else if (in_hs_s) begin
      x_d   = in_data;
      dec_d = in_dec;
      ctr_d = 5'd0;
    end else if (state_q == S_KEYEXP) begin
      kx_d  = kc_s[UNROLL];
      ctr_d = ctr_q + STEP;
      if (last_s) key_loaded_d = 1'b1;
    end else if (state_q == S_CRYPT) begin
`ifndef RISCV_CRYPTO_SM4_ITER_DEC_EN
      if (dec_q) begin
        ctr_d      = 5'd0;
        out_data_d = 128'h0;
        out_err_d  = 1'b1;
      end else begin
`else
      begin
`endif
        x_d   = xc_s[UNROLL];
        ctr_d = ctr_q + STEP;
        if (last_s) begin
          out_data_d = {xc_s[UNROLL][31:0], xc_s[UNROLL][63:32], xc_s[UNROLL][95:64], xc_s[UNROLL][127:96]};
          out_err_d  = 1'b0;
        end
      end
    end else begin
      ctr_d = ctr_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q      <= S_IDLE;
      ctr_q        <= 5'd0;
      kx_q         <= 128'h0;
      x_q          <= 128'h0;
      dec_q        <= 1'b0;
      out_data_q   <= 128'h0;
      out_err_q    <= 1'b0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      kx_q         <= kx_d;
      x_q          <= x_d;
      dec_q        <= dec_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      key_loaded_q <= key_loaded_d;
    end
  end

  // Round-key store; validity is tracked by key_loaded, so no reset is needed.
  always_ff @(posedge g_clk) begin
    if (state_q == S_KEYEXP) begin
      for (int u = 0; u < UNROLL; u++) rk_q[ctr_q + 5'(u)] <= kc_s[u+1][31:0];
    end
  end

  assign key_loaded = key_loaded_q;
  assign out_data   = out_data_q;
  assign out_err    = out_err_q;
endmodule

// File: tb/tb_riscv_crypto_sm4_iter.sv
// Directed self-checking bench for riscv_crypto_sm4_iter using the GB/T 32907 reference vector.
module tb_riscv_crypto_sm4_iter;
  localparam int UNROLL = 1;
  localparam int LAT    = 32 / UNROLL;
  localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

  logic         g_clk, g_resetn, key_valid, key_ready, key_loaded, in_valid, in_ready;
  logic         in_dec, out_valid, out_ready, out_err;
  logic [127:0] key, in_data, out_data;
  int total = 0;
  int bad   = 0;

  riscv_crypto_sm4_iter #(.UNROLL(UNROLL)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .key_valid(key_valid), .key_ready(key_ready),
    .key(key), .key_loaded(key_loaded), .in_valid(in_valid), .in_ready(in_ready),
    .in_dec(in_dec), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic load_key(input logic [127:0] k, output int lat);
    @(negedge g_clk);
    key = k;
    key_valid = 1'b1;
    @(negedge g_clk);
    key_valid = 1'b0;
    lat = 0;
    while (!key_loaded && lat < 200) begin
      @(negedge g_clk);
      lat++;
    end
    if (!key_loaded) lat = -1;
  endtask

  task automatic run_block(input logic [127:0] d, input logic dec, output int lat,
                           output logic [127:0] res, output logic err);
    @(negedge g_clk);
    in_data = d;
    in_dec = dec;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge g_clk);
    in_valid = 1'b0;
    in_dec = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge g_clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    res = out_data;
    err = out_err;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge g_clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    g_resetn = 1'b1;
    #1 g_resetn = 1'b0;
    #2;
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL reset_key_ready got=%b exp=1", key_ready); end
    total++; if (key_loaded !== 1'b0) begin bad++; $display("FAIL reset_key_loaded got=%b exp=0", key_loaded); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    @(negedge g_clk);
    @(negedge g_clk);
    g_resetn = 1'b1;
  endtask

  task automatic test_keyexp();
    int lat;
    load_key(KEY, lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL keyexp_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL keyexp_in_ready got=%b exp=1", in_ready); end
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL keyexp_key_ready got=%b exp=1", key_ready); end
  endtask

  task automatic test_encrypt();
    int lat; logic [127:0] res; logic err;
    run_block(KEY, 1'b0, lat, res, err);
    total++; if (lat != LAT) begin bad++; $display("FAIL enc_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (res !== CT) begin bad++; $display("FAIL enc_data got=%h exp=%h", res, CT); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL enc_err got=%b exp=0", err); end
    release_out();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL enc_release got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL enc_back_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_decrypt();
    int lat; logic [127:0] res; logic err;
    run_block(CT, 1'b1, lat, res, err);
`ifdef RISCV_CRYPTO_SM4_ITER_DEC_EN
    total++; if (lat != LAT) begin bad++; $display("FAIL dec_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (res !== KEY) begin bad++; $display("FAIL dec_data got=%h exp=%h", res, KEY); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL dec_err got=%b exp=0", err); end
`else
    total++; if (lat != 1) begin bad++; $display("FAIL dec_latency got=%0d exp=1", lat); end
    total++; if (res !== 128'h0) begin bad++; $display("FAIL dec_data got=%h exp=0", res); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL dec_err got=%b exp=1", err); end
`endif
    release_out();
  endtask

  task automatic test_hold();
    int lat; logic [127:0] res; logic err;
    run_block(KEY, 1'b0, lat, res, err);
    total++; if (res !== CT) begin bad++; $display("FAIL hold_first got=%h exp=%h", res, CT); end
    key_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge g_clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== CT || in_ready !== 1'b0 || key_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d got=v%b d=%h ir=%b kr=%b exp=v1 d=%h ir=0 kr=0",
                 i, out_valid, out_data, in_ready, key_ready, CT);
      end
    end
    key_valid = 1'b0;
    total++; if (key_loaded !== 1'b1) begin bad++; $display("FAIL hold_key_ignored got=%b exp=1", key_loaded); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat; logic [127:0] res; logic err;
    for (int n = 0; n < 2; n++) begin
      run_block(KEY, 1'b0, lat, res, err);
      total++; if (res !== CT || lat != LAT) begin bad++; $display("FAIL b2b_%0d got=%h lat=%0d exp=%h lat=%0d", n, res, lat, CT, LAT); end
      release_out();
    end
  endtask

  task automatic test_key_priority();
    int lat; logic [127:0] res; logic err;
    @(negedge g_clk);
    key = KEY;
    key_valid = 1'b1;
    in_data = KEY;
    in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL prio_in_ready got=%b exp=0", in_ready); end
    @(negedge g_clk);
    key_valid = 1'b0;
    in_valid = 1'b0;
    total++; if (key_loaded !== 1'b0 || key_ready !== 1'b0) begin bad++; $display("FAIL prio_keyexp got=kl%b kr%b exp=kl0 kr0", key_loaded, key_ready); end
    lat = 0;
    while (!key_loaded && lat < 200) begin
      @(negedge g_clk);
      lat++;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL prio_block_taken got=%b exp=0", out_valid); end
    end
    total++; if (lat != LAT) begin bad++; $display("FAIL prio_latency got=%0d exp=%0d", lat, LAT); end
    run_block(KEY, 1'b0, lat, res, err);
    total++; if (res !== CT) begin bad++; $display("FAIL prio_enc got=%h exp=%h", res, CT); end
    release_out();
  endtask

  task automatic test_reset_mid();
    int lat; logic [127:0] res; logic err;
    @(negedge g_clk);
    in_data = KEY;
    in_valid = 1'b1;
    @(negedge g_clk);
    in_valid = 1'b0;
    repeat (10) @(negedge g_clk);
    g_resetn = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
    total++; if (key_loaded !== 1'b0) begin bad++; $display("FAIL rst_mid_key_loaded got=%b exp=0", key_loaded); end
    total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_key_ready got=%b exp=1", key_ready); end
    @(negedge g_clk);
    g_resetn = 1'b1;
    load_key(KEY, lat);
    total++; if (lat != LAT) begin bad++; $display("FAIL rst_reload_latency got=%0d exp=%0d", lat, LAT); end
    run_block(KEY, 1'b0, lat, res, err);
    total++; if (res !== CT) begin bad++; $display("FAIL rst_reload_enc got=%h exp=%h", res, CT); end
    release_out();
  endtask

  initial begin
    key_valid = 1'b0; key = 128'h0; in_valid = 1'b0; in_dec = 1'b0;
    in_data = 128'h0; out_ready = 1'b0;
    test_reset();
    test_keyexp();
    test_encrypt();
    test_decrypt();
    test_hold();
    test_back_to_back();
    test_key_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
